updn_sweep_ctrl: RTL and testbench
==================================

Name: updn_sweep_ctrl

Overview:
Sequencer for the 16-bit up/down counter (data_in, ld_cnt, updn_cnt, count_enb, data_out).
- Loads a start value into the counter, then drives it in a triangle sweep between a low bound and a high bound.
- Counts completed sweeps, then stops the counter and reports done.
- Sits between the configuration/control logic and the counter. It is the only driver of the counter's control inputs.

Parameters:
WIDTH, 16, counter data width; must match the counter.
SWEEP_W, 8, width of sweep-count config and status.

Ports:
clk  input  1  clock, rising edge
rst_  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled in IDLE only
stop  input  1  abort sweep; sampled in LOAD/UP/DOWN
cfg_start  input  WIDTH  initial counter value
cfg_lo  input  WIDTH  low bound (unsigned)
cfg_hi  input  WIDTH  high bound (unsigned)
cfg_sweeps  input  SWEEP_W  sweeps to run; 0 = run until stop
cnt_val  input  WIDTH  counter data_out
data_in  output  WIDTH  counter load value
ld_cnt  output  1  counter load, active low (0 = load)
updn_cnt  output  1  1 = up, 0 = down
count_enb  output  1  counter count enable
busy  output  1  high in LOAD/UP/DOWN
done  output  1  one-cycle pulse on normal completion
cfg_err  output  1  one-cycle pulse on rejected start
sweep_cnt  output  SWEEP_W  completed sweeps in current run

Behaviour:
- Reset (async, rst_=0), all outputs registered unless noted:
  - state=IDLE, data_in=0, ld_cnt=1, updn_cnt=1, count_enb=0.
  - busy=0, done=0, cfg_err=0, sweep_cnt=0.
  - Applies immediately, including mid-sweep. The counter is left holding its current value.
- States: IDLE, LOAD, UP, DOWN.
- Config latch:
  - cfg_start/cfg_lo/cfg_hi/cfg_sweeps are latched on the edge where start=1 is accepted in IDLE.
  - Config changes after that edge are ignored until the next start.
- Config check at start:
  - Valid: cfg_lo < cfg_hi and cfg_lo <= cfg_start <= cfg_hi.
  - Invalid: cfg_err=1 for one cycle, stay IDLE, counter untouched.
- IDLE -> LOAD on valid start. sweep_cnt cleared to 0.
- LOAD (exactly 1 cycle):
  - ld_cnt=0, data_in=latched start, count_enb=0.
  - Next state is DOWN if start == hi, else UP.
- Counter outputs in UP/DOWN are Mealy on cnt_val, so there is no overshoot:
  - UP: updn_cnt=1, count_enb=1. When cnt_val == hi: updn_cnt=0 that same cycle and state -> DOWN. The value hi appears for exactly one cycle.
  - DOWN: updn_cnt=0, count_enb=1. When cnt_val == lo, sweep_cnt increments at the edge, then:
    - If cfg_sweeps != 0 and sweep_cnt+1 == cfg_sweeps: count_enb=0 that cycle, state -> IDLE, done=1 in the following cycle. Counter holds lo.
    - Otherwise: updn_cnt=1 that cycle, state -> UP.
- One sweep = one arrival at lo while in DOWN.
- Latency, start accepted at edge T:
  - LOAD during cycle T..T+1.
  - cnt_val == start after edge T+1.
  - First count step at edge T+2.
- stop:
  - In LOAD/UP/DOWN: count_enb=0 and ld_cnt=1 combinationally that cycle, state -> IDLE.
  - No done pulse; sweep_cnt retains its value.
  - stop and start together in IDLE: start wins, stop is ignored.
- sweep_cnt saturates at all-ones in continuous mode.
- ld_cnt is never 0 at the same time as count_enb is 1.
- In IDLE: count_enb=0, ld_cnt=1, and updn_cnt holds its last value.

Optional Feature:
Macro: UPDN_SWEEP_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in UP/DOWN: count_enb=0, state and direction frozen, bound compares still evaluated but no transition taken.
  - stop overrides pause.
  - pause has no effect in IDLE/LOAD.
- Not defined: no pause port; behaviour as above.

Test Plan:
1. start=5, lo=3, hi=7, sweeps=1 -> cnt_val sequence 5,6,7,6,5,4,3. count_enb drops while cnt_val=3. done pulses once. sweep_cnt=1. Counter holds 3.
2. start=7, lo=3, hi=7, sweeps=2 -> LOAD goes straight to DOWN: 7,6,5,4,3,4,5,6,7,6,5,4,3, then done. sweep_cnt=2.
3. Invalid start: lo=7, hi=7; or start=9 with lo=3, hi=7 -> cfg_err single pulse, busy stays 0, ld_cnt/count_enb never asserted.
4. sweeps=0, lo=0, hi=2, stop asserted while cnt_val=1 in DOWN -> count_enb=0 the same cycle, IDLE next, no done, counter holds 1.
5. rst_ driven low mid-UP at cnt_val=6 -> outputs take reset values immediately (async). After release, start with new config sweeps correctly.
6. UPDN_SWEEP_PAUSE_EN: pause held 3 cycles at cnt_val=6 in UP -> cnt_val stays 6 for those 3 cycles, then resumes 7,6,...; with stop during pause -> IDLE.

Source files
------------

// File: rtl/updn_sweep_ctrl.sv
// Sequencer driving a 16-bit up/down counter in a triangle sweep between cfg_lo and cfg_hi.
// Optional pause input is enabled by defining UPDN_SWEEP_PAUSE_EN.
module updn_sweep_ctrl #(
  parameter int WIDTH   = 16,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               start,
  input  logic               stop,
`ifdef UPDN_SWEEP_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [WIDTH-1:0]   cfg_start,
  input  logic [WIDTH-1:0]   cfg_lo,
  input  logic [WIDTH-1:0]   cfg_hi,
  input  logic [SWEEP_W-1:0] cfg_sweeps,
  input  logic [WIDTH-1:0]   cnt_val,
  output logic [WIDTH-1:0]   data_in,
  output logic               ld_cnt,
  output logic               updn_cnt,
  output logic               count_enb,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UP, S_DOWN} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [SWEEP_W-1:0] r_sweeps;
  logic [WIDTH-1:0]   r_data_in;
  logic               r_updn;
  logic               r_done;
  logic               r_err;
  logic [SWEEP_W-1:0] r_sweep_cnt;

  logic               w_pause;
  logic               w_run;
  logic               w_at_hi;
  logic               w_at_lo;
  logic               w_cfg_ok;
  logic [SWEEP_W:0]   w_sweep_next;
  logic               w_last;
  logic               w_sat;
  logic               w_finish;
  logic               w_updn;

`ifdef UPDN_SWEEP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_run        = (r_state == S_UP) || (r_state == S_DOWN);
  assign w_at_hi      = (cnt_val == r_hi);
  assign w_at_lo      = (cnt_val == r_lo);
  assign w_cfg_ok     = (cfg_lo < cfg_hi) && (cfg_lo <= cfg_start) && (cfg_start <= cfg_hi);
  assign w_sweep_next = {1'b0, r_sweep_cnt} + (SWEEP_W+1)'(1);
  assign w_last       = (r_sweeps != '0) && (w_sweep_next == {1'b0, r_sweeps});
  assign w_sat        = (r_sweep_cnt == '1);
  assign w_finish     = (r_state == S_DOWN) && w_at_lo && w_last && !w_pause;

  // Direction turns on the same cycle a bound is seen so the counter never overshoots.
  always_comb begin
    w_updn = r_updn;
    case (r_state)
      S_UP:    w_updn = !(w_at_hi && !w_pause);
      S_DOWN:  w_updn = w_at_lo && !w_last && !w_pause;
      default: w_updn = r_updn;
    endcase
  end

  assign data_in   = r_data_in;
  assign ld_cnt    = !((r_state == S_LOAD) && !stop);
  assign updn_cnt  = w_updn;
  assign count_enb = w_run && !stop && !w_pause && !w_finish;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign cfg_err   = r_err;
  assign sweep_cnt = r_sweep_cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_sweeps    <= '0;
      r_data_in   <= '0;
      r_updn      <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sweep_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_lo        <= cfg_lo;
              r_hi        <= cfg_hi;
              r_sweeps    <= cfg_sweeps;
              r_data_in   <= cfg_start;
              r_sweep_cnt <= '0;
              r_state     <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (stop)                    r_state <= S_IDLE;
          else if (r_data_in == r_hi)  r_state <= S_DOWN;
          else                         r_state <= S_UP;
        end
        S_UP: begin
          r_updn <= w_updn;
          if (stop)                     r_state <= S_IDLE;
          else if (!w_pause && w_at_hi) r_state <= S_DOWN;
        end
        S_DOWN: begin
          r_updn <= w_updn;
          if (stop) begin
            r_state <= S_IDLE;
          end else if (!w_pause && w_at_lo) begin
            if (!w_sat) r_sweep_cnt <= w_sweep_next[SWEEP_W-1:0];
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_UP;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// Self-checking bench for updn_sweep_ctrl: models the counter and predicts each cycle from the sweep rules.
// Pause scenarios are built only when UPDN_SWEEP_PAUSE_EN is defined.
module tb_updn_sweep_ctrl;
  localparam int W  = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
`ifdef UPDN_SWEEP_PAUSE_EN
  logic          pause = 1'b0;
`endif
  logic [W-1:0]  cfg_start = '0;
  logic [W-1:0]  cfg_lo = '0;
  logic [W-1:0]  cfg_hi = '0;
  logic [SW-1:0] cfg_sweeps = '0;
  logic [W-1:0]  cntVal = '0;
  logic [W-1:0]  data_in;
  logic          ld_cnt, updn_cnt, count_enb, busy, done, cfg_err;
  logic [SW-1:0] sweep_cnt;

  always #5 clk = ~clk;

  updn_sweep_ctrl #(.WIDTH(W), .SWEEP_W(SW)) dut (
    .clk(clk), .rst_(rst_), .start(start), .stop(stop),
`ifdef UPDN_SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .cfg_start(cfg_start), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_sweeps(cfg_sweeps),
    .cnt_val(cntVal), .data_in(data_in), .ld_cnt(ld_cnt), .updn_cnt(updn_cnt),
    .count_enb(count_enb), .busy(busy), .done(done), .cfg_err(cfg_err), .sweep_cnt(sweep_cnt)
  );

  // The counter being sequenced: active-low load, otherwise count when enabled; untouched by rst_.
  always @(posedge clk) begin
    if (!ld_cnt)        cntVal <= data_in;
    else if (count_enb) cntVal <= updn_cnt ? cntVal + 16'd1 : cntVal - 16'd1;
  end

  int checks = 0;
  int errors = 0;

  bit            chkEn = 1'b0;
  logic          expBusy, expDone, expErr, expLd, expCe, expUpdnCare, expUpdn;
  logic [W-1:0]  expCnt, expData;
  logic [SW-1:0] expSweep;
  logic [W-1:0]  mCnt = '0;
  logic [W-1:0]  mData = '0;
  logic [SW-1:0] mSweep = '0;
  logic [W-1:0]  seq[$];

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("busy", 32'(busy), 32'(expBusy));
    checkValue("done", 32'(done), 32'(expDone));
    checkValue("cfg_err", 32'(cfg_err), 32'(expErr));
    checkValue("ld_cnt", 32'(ld_cnt), 32'(expLd));
    checkValue("count_enb", 32'(count_enb), 32'(expCe));
    if (expUpdnCare) checkValue("updn_cnt", 32'(updn_cnt), 32'(expUpdn));
    checkValue("cnt_val", 32'(cntVal), 32'(expCnt));
    checkValue("sweep_cnt", 32'(sweep_cnt), 32'(expSweep));
    checkValue("data_in", 32'(data_in), 32'(expData));
  endtask

  always @(negedge clk) begin
    #2;
    if (chkEn) checkOutput();
  end

  function automatic logic [SW-1:0] sat8(input int n);
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic setPause(input bit v);
`ifdef UPDN_SWEEP_PAUSE_EN
    pause = v;
`else
    if (v) $display("[TB] pause requested without pause port");
`endif
  endtask

  task automatic setIdle(input bit d, input bit e);
    expBusy = 1'b0; expDone = d; expErr = e; expLd = 1'b1; expCe = 1'b0;
    expUpdnCare = 1'b0; expUpdn = 1'b0;
    expCnt = mCnt; expSweep = mSweep; expData = mData;
  endtask

  task automatic setRun(input logic ld, input logic [W-1:0] c, input logic ce,
                        input logic care, input logic u, input logic [SW-1:0] swv);
    expBusy = 1'b1; expDone = 1'b0; expErr = 1'b0; expLd = ld; expCe = ce;
    expUpdnCare = care; expUpdn = u;
    expCnt = c; expSweep = swv; expData = mData;
  endtask

  // Triangle walk from s; each arrival at lo on the way down is one sweep.
  task automatic buildSeq(input logic [W-1:0] s, lo, hi, input logic [SW-1:0] sw, input int maxLen);
    logic [W-1:0] cur;
    bit goingUp;
    int n;
    seq.delete();
    cur = s;
    goingUp = (s != hi);
    n = 0;
    seq.push_back(cur);
    while (seq.size() < maxLen) begin
      if (goingUp) cur = cur + 16'd1; else cur = cur - 16'd1;
      seq.push_back(cur);
      if (cur == hi) goingUp = 1'b0;
      else if (cur == lo && !goingUp) begin
        n++;
        if (sw != 0 && n == int'(sw)) break;
        goingUp = 1'b1;
      end
    end
  endtask

  task automatic scrambleCfg();
    cfg_start = 16'($urandom); cfg_lo = 16'($urandom); cfg_hi = 16'($urandom);
    cfg_sweeps = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [W-1:0] s, lo, hi, input logic [SW-1:0] sw,
                               input int stopIn, input int pauseAt, input int pauseLen, input bit pauseStop);
    bit valid, aborted;
    int stopAt, L, n;
    logic ce, u;
    valid = (lo < hi) && (lo <= s) && (s <= hi);
    @(negedge clk);
    cfg_start = s; cfg_lo = lo; cfg_hi = hi; cfg_sweeps = sw;
    start = 1'b1; stop = 1'($urandom_range(0, 1)); setPause(1'b0);
    setIdle(1'b0, 1'b0);
    if (!valid) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; scrambleCfg();
      setIdle(1'b0, 1'b1);
      @(negedge clk);
      setIdle(1'b0, 1'b0);
      return;
    end
    stopAt = stopIn;
    buildSeq(s, lo, hi, sw, (sw == 0) ? stopAt + 3 : 100000);
    while (stopAt >= 0 && seq[stopAt] == lo) stopAt++;
    if (stopAt >= seq.size() - 1) stopAt = -1;
    if (stopAt >= 0) while (seq.size() > stopAt + 1) void'(seq.pop_back());
    L = seq.size();
    @(negedge clk);
    start = 1'($urandom_range(0, 1)); stop = 1'b0; scrambleCfg();
    mData = s; mSweep = '0;
    setRun(1'b0, mCnt, 1'b0, 1'b0, 1'b0, 8'd0);
    n = 0;
    aborted = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (i == pauseAt) begin
        for (int p = 0; p < pauseLen; p++) begin
          @(negedge clk);
          setPause(1'b1);
          stop = pauseStop && (p == pauseLen - 1);
          start = 1'($urandom_range(0, 1));
          setRun(1'b1, seq[i], 1'b0, 1'b0, 1'b0, sat8(n));
          if (stop) begin
            aborted = 1'b1;
            mCnt = seq[i];
          end
        end
        if (aborted) break;
      end
      @(negedge clk);
      setPause(1'b0);
      stop = (i == stopAt);
      start = 1'($urandom_range(0, 1));
      scrambleCfg();
      ce = (i != L - 1);
      u = 1'b0;
      if (ce) u = (seq[i+1] > seq[i]);
      setRun(1'b1, seq[i], ce, ce, u, sat8(n));
      if (i >= 1 && seq[i] == lo && i != stopAt) n++;
      mCnt = seq[i];
    end
    @(negedge clk);
    start = 1'b0; stop = 1'($urandom_range(0, 1)); setPause(1'b0);
    mSweep = sat8(n);
    setIdle(!aborted && stopAt < 0, 1'b0);
    if (!aborted && stopAt < 0) begin
      expUpdnCare = 1'b1; expUpdn = 1'b0;
    end
    @(negedge clk);
    stop = 1'b0;
    setIdle(1'b0, 1'b0);
  endtask

  logic [W-1:0] lit1 [7]  = '{16'd5, 16'd6, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3};
  logic [W-1:0] lit2 [13] = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd4, 16'd5,
                              16'd6, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3};

  initial begin
    logic [W-1:0] lo, hi, s;
    logic [SW-1:0] sw;
    int stopAt, mode;

    buildSeq(16'd5, 16'd3, 16'd7, 8'd1, 100000);
    checkValue("model_len1", 32'(seq.size()), 32'd7);
    for (int i = 0; i < 7 && i < seq.size(); i++) checkValue("model_seq1", 32'(seq[i]), 32'(lit1[i]));
    buildSeq(16'd7, 16'd3, 16'd7, 8'd2, 100000);
    checkValue("model_len2", 32'(seq.size()), 32'd13);
    for (int i = 0; i < 13 && i < seq.size(); i++) checkValue("model_seq2", 32'(seq[i]), 32'(lit2[i]));

    @(negedge clk);
    setIdle(1'b0, 1'b0);
    expUpdnCare = 1'b1; expUpdn = 1'b1;
    chkEn = 1'b1;
    @(negedge clk);
    rst_ = 1'b1;

    applyStimulus(16'd5, 16'd3, 16'd7, 8'd1, -1, -1, 0, 1'b0);
    #2;
    checkValue("tp1_sweep", 32'(sweep_cnt), 32'd1);
    checkValue("tp1_hold", 32'(cntVal), 32'd3);

    applyStimulus(16'd7, 16'd3, 16'd7, 8'd2, -1, -1, 0, 1'b0);
    #2;
    checkValue("tp2_sweep", 32'(sweep_cnt), 32'd2);

    applyStimulus(16'd5, 16'd7, 16'd7, 8'd1, -1, -1, 0, 1'b0);
    applyStimulus(16'd9, 16'd3, 16'd7, 8'd1, -1, -1, 0, 1'b0);

    applyStimulus(16'd0, 16'd0, 16'd2, 8'd0, 3, -1, 0, 1'b0);
    #2;
    checkValue("tp4_hold", 32'(cntVal), 32'd1);
    checkValue("tp4_nodone", 32'(done), 32'd0);

    // Reset mid-UP while the counter shows 6.
    @(negedge clk);
    cfg_start = 16'd5; cfg_lo = 16'd3; cfg_hi = 16'd7; cfg_sweeps = 8'd0;
    start = 1'b1; stop = 1'b0;
    setIdle(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    mData = 16'd5; mSweep = '0;
    setRun(1'b0, mCnt, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    setRun(1'b1, 16'd5, 1'b1, 1'b1, 1'b1, 8'd0);
    @(negedge clk);
    rst_ = 1'b0;
    mData = '0; mSweep = '0; mCnt = 16'd6;
    setIdle(1'b0, 1'b0);
    expUpdnCare = 1'b1; expUpdn = 1'b1;
    @(negedge clk);
    setIdle(1'b0, 1'b0);
    expUpdnCare = 1'b1; expUpdn = 1'b1;
    @(negedge clk);
    rst_ = 1'b1;
    setIdle(1'b0, 1'b0);
    applyStimulus(16'd4, 16'd2, 16'd6, 8'd2, -1, -1, 0, 1'b0);
    #2;
    checkValue("tp5_sweep", 32'(sweep_cnt), 32'd2);

    applyStimulus(16'd0, 16'd0, 16'd1, 8'd0, 600, -1, 0, 1'b0);
    #2;
    checkValue("sweep_saturate", 32'(sweep_cnt), 32'd255);

`ifdef UPDN_SWEEP_PAUSE_EN
    applyStimulus(16'd5, 16'd3, 16'd7, 8'd1, -1, 1, 3, 1'b0);
    #2;
    checkValue("tp6_sweep", 32'(sweep_cnt), 32'd1);
    applyStimulus(16'd5, 16'd3, 16'd7, 8'd1, -1, 1, 3, 1'b1);
    #2;
    checkValue("tp6_stop_hold", 32'(cntVal), 32'd6);
`endif

    for (int r = 0; r < 60; r++) begin
      lo = 16'($urandom_range(0, 65000));
      hi = lo + 16'($urandom_range(1, 6));
      s  = 16'($urandom_range(int'(lo), int'(hi)));
      sw = 8'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      if (mode == 0) hi = lo - 16'($urandom_range(0, 3));
      else if (mode == 1) s = hi + 16'd1;
      else if (mode == 2 && lo != 0) s = lo - 16'd1;
      if (sw == 0) stopAt = $urandom_range(0, 30);
      else if ($urandom_range(0, 2) == 0) stopAt = $urandom_range(0, 20);
      else stopAt = -1;
`ifdef UPDN_SWEEP_PAUSE_EN
      applyStimulus(s, lo, hi, sw, stopAt, $urandom_range(0, 8), $urandom_range(0, 3), 1'b0);
`else
      applyStimulus(s, lo, hi, sw, stopAt, -1, 0, 1'b0);
`endif
    end

    @(negedge clk);
    #3;
    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
